// File: rtl/delayed_memory.sv
// Dual-port word memory with a fixed access latency on each port.
// Port 1 is read-only. Port 2 reads or writes over a shared bidirectional data bus.
module delayed_memory #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 ready1,
  input  logic                 read_m2,
  input  logic                 write_m2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 ready2
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

  state_t                 state1_reg, state1_next;
  logic [3:0]             cnt1_reg, cnt1_next;
  logic [ADDR_BITS-1:0]   addr1_reg, addr1_next;
  logic                   done1;
  logic                   ready1_reg;
  logic [WORD_SIZE-1:0]   data1_reg;

  state_t                 state2_reg, state2_next;
  logic [3:0]             cnt2_reg, cnt2_next;
  logic [ADDR_BITS-1:0]   addr2_reg, addr2_next;
  logic [WORD_SIZE-1:0]   wdata2_reg, wdata2_next;
  logic                   wr2_reg, wr2_next;
  logic                   done2;
  logic                   ready2_reg;
  logic [WORD_SIZE-1:0]   rdata2_reg;

  // Upper address bits are ignored so addresses wrap onto the array.
  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_addr_unused
      logic unused_upper;
      assign unused_upper = ^{address1[WORD_SIZE-1:ADDR_BITS], address2[WORD_SIZE-1:ADDR_BITS]};
    end
  endgenerate

  always_comb begin
    state1_next = state1_reg;
    cnt1_next   = cnt1_reg;
    addr1_next  = addr1_reg;
    done1       = 1'b0;
    case (state1_reg)
      S_IDLE, S_RESP: begin
        if (read_m1) begin
          state1_next = S_WAIT;
          cnt1_next   = CNT_INIT;
          addr1_next  = address1[ADDR_BITS-1:0];
        end else begin
          state1_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt1_reg == 4'd0) begin
          state1_next = S_RESP;
          done1       = 1'b1;
        end else begin
          cnt1_next = cnt1_reg - 4'd1;
        end
      end
      default: state1_next = S_IDLE;
    endcase
  end

  // Both request lines high is treated as a read; the write is dropped.
  always_comb begin
    state2_next = state2_reg;
    cnt2_next   = cnt2_reg;
    addr2_next  = addr2_reg;
    wdata2_next = wdata2_reg;
    wr2_next    = wr2_reg;
    done2       = 1'b0;
    case (state2_reg)
      S_IDLE, S_RESP: begin
        if (read_m2 || write_m2) begin
          state2_next = S_WAIT;
          cnt2_next   = CNT_INIT;
          addr2_next  = address2[ADDR_BITS-1:0];
          wdata2_next = data2;
          wr2_next    = write_m2 && !read_m2;
        end else begin
          state2_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt2_reg == 4'd0) begin
          state2_next = S_RESP;
          done2       = 1'b1;
        end else begin
          cnt2_next = cnt2_reg - 4'd1;
        end
      end
      default: state2_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state1_reg <= S_IDLE;
      cnt1_reg   <= 4'd0;
      addr1_reg  <= '0;
      ready1_reg <= 1'b0;
      data1_reg  <= '0;
    end else begin
      state1_reg <= state1_next;
      cnt1_reg   <= cnt1_next;
      addr1_reg  <= addr1_next;
      ready1_reg <= done1;
      if (done1) data1_reg <= mem[addr1_reg];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state2_reg <= S_IDLE;
      cnt2_reg   <= 4'd0;
      addr2_reg  <= '0;
      wdata2_reg <= '0;
      wr2_reg    <= 1'b0;
      ready2_reg <= 1'b0;
      rdata2_reg <= '0;
    end else begin
      state2_reg <= state2_next;
      cnt2_reg   <= cnt2_next;
      addr2_reg  <= addr2_next;
      wdata2_reg <= wdata2_next;
      wr2_reg    <= wr2_next;
      ready2_reg <= done2;
      if (done2 && !wr2_reg) rdata2_reg <= mem[addr2_reg];
    end
  end

  // Write commits only on the completion edge; reset forces IDLE so a pending write never lands.
  always_ff @(posedge clk) begin
    if (done2 && wr2_reg) mem[addr2_reg] <= wdata2_reg;
  end

  assign data1  = data1_reg;
  assign ready1 = ready1_reg;
  assign ready2 = ready2_reg;
  assign data2  = read_m2 ? rdata2_reg : {WORD_SIZE{1'bz}};

endmodule

// File: doc/delayed_memory.md
DELAYED_MEMORY -- requirements
Module: delayed_memory

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width in bits.
REQ-002 Parameter ADDR_BITS, default 8, array index width; depth is 2^ADDR_BITS words.
REQ-003 Parameter LATENCY, default 2, access latency in cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 read_m1  input  1  port-1 (instruction) read request.
REQ-007 address1  input  WORD_SIZE  port-1 word address.
REQ-008 data1  output  WORD_SIZE  port-1 read data, registered.
REQ-009 ready1  output  1  port-1 completion pulse, registered.
REQ-010 read_m2  input  1  port-2 (data) read request.
REQ-011 write_m2  input  1  port-2 write request.
REQ-012 address2  input  WORD_SIZE  port-2 word address.
REQ-013 data2  inout  WORD_SIZE  port-2 bidirectional data bus.
REQ-014 ready2  output  1  port-2 completion pulse, registered.

Function
REQ-015 Storage SHALL be 2^ADDR_BITS words of WORD_SIZE bits; index = address[ADDR_BITS-1:0]; upper address bits ignored (wrap-around).
REQ-016 Each port SHALL run an independent FSM: IDLE, WAIT, RESP.
REQ-017 IDLE: request sampled high at edge N -> capture address (and port-2 write data and op) -> WAIT, down-counter = LATENCY-1.
REQ-018 WAIT: counter decrements each edge; at the edge where it is 0 -> RESP.
REQ-019 Entering RESP at edge N+LATENCY: ready pulses high for exactly that cycle; port-1 data1 and port-2 read register load mem[captured index].
REQ-020 Port-2 write SHALL commit mem[captured index] = captured data at the edge entering RESP; never earlier.
REQ-021 RESP: request high -> capture new request, go to WAIT (back-to-back); else -> IDLE; ready deasserts either way.
REQ-022 Requests in WAIT SHALL be ignored; address/data changes in WAIT SHALL NOT affect the pending access.
REQ-023 read_m2 and write_m2 both high at capture -> read; write discarded.
REQ-024 Port-2 write data SHALL be sampled from data2 at the capture edge.
REQ-025 data2 SHALL be driven with the port-2 read register while read_m2=1, high-impedance otherwise.
REQ-026 data1 and the port-2 read register SHALL hold their last value until the next read completion.
REQ-027 Port-1 read completing on the same edge as a port-2 write to the same index SHALL return the pre-write value.
REQ-028 Port-2 read captured while a port-2 write is pending cannot occur (single FSM); same-index port-1 read completing after the write edge SHALL return the new value.
REQ-029 Memory contents SHALL be loadable only by simulation initialisation; no other write path.

Reset
REQ-030 reset_n low SHALL immediately force both FSMs to IDLE, counters to 0, ready1=ready2=0, data1=0, port-2 read register=0.
REQ-031 Reset mid-access SHALL discard the pending access; a pending write SHALL NOT commit.
REQ-032 Memory array contents SHALL be unaffected by reset.
REQ-033 First request SHALL be accepted at the first rising edge after reset_n returns high.

Verification
REQ-034 LATENCY=2, mem[0x10]=0x1234, read_m1=1 address1=0x0010 at edge N -> ready1=1 and data1=0x1234 after edge N+2 only; ready1=0 after N+3.
REQ-035 write_m2=1 address2=0x0020 data2=0xBEEF at edge N, then read_m2 at 0x0020 -> mem unchanged before edge N+2; read returns 0xBEEF on data2 while read_m2=1.
REQ-036 read_m2=write_m2=1 address2=0x0005 data2=0xAAAA, mem[5]=0x0001 -> read completes with 0x0001; mem[5] stays 0x0001.
REQ-037 Address 0x0110 with ADDR_BITS=8 -> accesses index 0x10 (wrap); read_m1 held high continuously -> ready1 pulses every LATENCY+1 cycles.
REQ-038 Write to 0x30 pending, reset_n low one cycle before commit -> ready2 never pulses; mem[0x30] retains old value; data1=0.
REQ-039 Port-1 read and port-2 write to 0x40 completing same edge, old 0x0000, new 0x5555 -> data1=0x0000; subsequent port-1 read returns 0x5555.
